// File: rtl/ucfg_spi_loader.sv
`default_nettype none
// ============================================================================
// Module      : ucfg_spi_loader
// Description : SPI-slave loader for 8 x 8-bit analog configuration registers,
//               with serial read-back on miso_o.
// Revision    : 1.0 - initial release
// ============================================================================
module ucfg_spi_loader #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [63:0] RESET_CFG   = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk_i,
    input  logic        cs_n_i,
    input  logic        mosi_i,
    output logic        miso_o,
    output logic        miso_oe,
    output logic [63:0] cfg_o,
    output logic        cfg_upd_o,
    output logic [2:0]  cfg_addr_o
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_HDR  = 2'd1;
    localparam logic [1:0] c_ST_DATA = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;
    logic                   r_mosi_q;
    logic                   r_sclk_rise;
    logic                   r_sclk_fall;
    logic                   r_cs_rise;
    logic                   r_cs_fall;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic        w_restart;
    logic        w_shift_en;
    logic        w_hdr_done;
    logic        w_frame_done;

    logic [4:0]  r_cnt;
    logic [6:0]  r_shift;
    logic        r_wr_flag;
    logic [2:0]  r_addr_lat;
    logic [7:0]  r_rd_sr;
    logic        r_wr_go;
    logic [7:0]  r_wr_data;
    logic [63:0] r_cfg;
    logic        r_upd;
    logic [2:0]  r_cfg_addr;

    logic w_sclk_s;
    logic w_cs_s;
    logic w_mosi_s;

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

    // Edge strobes are registered, so data is carried alongside with r_mosi_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
            r_mosi_q    <= 1'b0;
            r_sclk_rise <= 1'b0;
            r_sclk_fall <= 1'b0;
            r_cs_rise   <= 1'b0;
            r_cs_fall   <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_i};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n_i};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_i};
            r_sclk_d    <= w_sclk_s;
            r_cs_d      <= w_cs_s;
            r_mosi_q    <= w_mosi_s;
            r_sclk_rise <= w_sclk_s & ~r_sclk_d;
            r_sclk_fall <= ~w_sclk_s & r_sclk_d;
            r_cs_rise   <= w_cs_s & ~r_cs_d;
            r_cs_fall   <= ~w_cs_s & r_cs_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // cs_n edges take priority over sclk, so a cs_n rise on the 16th rise aborts.
    always_comb begin
        w_next_state = r_state;
        w_restart    = 1'b0;
        w_shift_en   = 1'b0;
        w_hdr_done   = 1'b0;
        w_frame_done = 1'b0;
        if (r_cs_fall) begin
            w_next_state = c_ST_HDR;
            w_restart    = 1'b1;
        end else if (r_cs_rise) begin
            w_next_state = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_HDR: begin
                    if (r_sclk_rise) begin
                        w_shift_en = 1'b1;
                        if (r_cnt == 5'd7) begin
                            w_next_state = c_ST_DATA;
                            w_hdr_done   = 1'b1;
                        end
                    end
                end
                c_ST_DATA: begin
                    if (r_sclk_rise) begin
                        w_shift_en = 1'b1;
                        if (r_cnt == 5'd15) begin
                            w_next_state = c_ST_DONE;
                            w_frame_done = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= 5'd0;
            r_shift    <= 7'd0;
            r_wr_flag  <= 1'b0;
            r_addr_lat <= 3'd0;
            r_rd_sr    <= 8'd0;
            r_wr_go    <= 1'b0;
            r_wr_data  <= 8'd0;
            r_cfg      <= RESET_CFG;
            r_upd      <= 1'b0;
            r_cfg_addr <= 3'd0;
        end else begin
            if (w_restart) begin
                r_cnt   <= 5'd0;
                r_shift <= 7'd0;
            end else if (w_shift_en) begin
                r_cnt   <= r_cnt + 5'd1;
                r_shift <= {r_shift[5:0], r_mosi_q};
            end

            // Header bit 15 sits in r_shift[6] when the 8th bit arrives.
            if (w_restart) begin
                r_wr_flag <= 1'b0;
                r_rd_sr   <= 8'd0;
            end else if (w_hdr_done) begin
                r_wr_flag  <= r_shift[6];
                r_addr_lat <= r_shift[5:3];
                r_rd_sr    <= r_shift[6] ? 8'd0 : r_cfg[{r_shift[5:3], 3'b000} +: 8];
            end else if (r_state == c_ST_DATA && r_sclk_fall && r_cnt >= 5'd9) begin
                r_rd_sr <= {r_rd_sr[6:0], 1'b0};
            end

            r_wr_go <= w_frame_done & r_wr_flag;
            if (w_frame_done) begin
                r_wr_data <= {r_shift, r_mosi_q};
            end

            r_upd <= 1'b0;
            if (r_wr_go) begin
                r_cfg[{r_addr_lat, 3'b000} +: 8] <= r_wr_data;
                r_upd      <= 1'b1;
                r_cfg_addr <= r_addr_lat;
            end
        end
    end

    assign miso_o     = r_rd_sr[7] & ~r_wr_flag;
    assign miso_oe    = ~r_cs_d;
    assign cfg_o      = r_cfg;
    assign cfg_upd_o  = r_upd;
    assign cfg_addr_o = r_cfg_addr;

endmodule
`default_nettype wire

// File: tb/tb_ucfg_spi_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ucfg_spi_loader
// Description : Directed self-checking bench for ucfg_spi_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ucfg_spi_loader;

    localparam int          SYNC_STAGES = 2;
    localparam logic [63:0] RESET_CFG   = 64'h0123456789ABCDEF;
    localparam int          HALF        = 6;

    logic        clk;
    logic        rst;
    logic        sclk_i;
    logic        cs_n_i;
    logic        mosi_i;
    logic        miso_o;
    logic        miso_oe;
    logic [63:0] cfg_o;
    logic        cfg_upd_o;
    logic [2:0]  cfg_addr_o;

    int          n_cmp;
    int          n_bad;
    int          upd_cnt;
    logic [2:0]  last_addr;
    logic [63:0] exp_cfg;
    int          lat;

    ucfg_spi_loader #(
        .SYNC_STAGES(SYNC_STAGES),
        .RESET_CFG  (RESET_CFG)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk_i    (sclk_i),
        .cs_n_i    (cs_n_i),
        .mosi_i    (mosi_i),
        .miso_o    (miso_o),
        .miso_oe   (miso_oe),
        .cfg_o     (cfg_o),
        .cfg_upd_o (cfg_upd_o),
        .cfg_addr_o(cfg_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        upd_cnt   = 0;
        last_addr = 3'd0;
    end

    always @(negedge clk) begin
        if (cfg_upd_o) begin
            upd_cnt   = upd_cnt + 1;
            last_addr = cfg_addr_o;
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Shift nbits of w (zeros beyond 16); optional cs_n raise and latency probe.
    task automatic spi_xfer(input logic [15:0] w, input int nbits, input bit raise_cs,
                            input bit measure, output logic [7:0] rd);
        logic [63:0] prev;
        rd     = 8'd0;
        cs_n_i = 1'b0;
        wait_n(HALF);
        for (int i = 0; i < nbits; i++) begin
            mosi_i = (i < 16) ? w[15-i] : 1'b0;
            wait_n(HALF);
            if (i >= 8 && i < 16) rd[15-i] = miso_o;
            prev   = cfg_o;
            sclk_i = 1'b1;
            if (measure && i == 15) begin
                lat = -1;
                for (int n = 0; n < 20 && lat < 0; n++) begin
                    @(posedge clk);
                    #1;
                    if (cfg_o !== prev) lat = n;
                end
                @(negedge clk);
            end else begin
                wait_n(HALF);
            end
            sclk_i = 1'b0;
        end
        wait_n(HALF);
        if (raise_cs) cs_n_i = 1'b1;
        wait_n(2 * HALF);
    endtask

    task automatic test_reset;
        logic [7:0] rd;
        int         u0;
        rst = 1'b1; cs_n_i = 1'b1; sclk_i = 1'b0; mosi_i = 1'b0;
        wait_n(2);
        rst = 1'b0;
        wait_n(4);
        exp_cfg = RESET_CFG;
        n_cmp++; if (cfg_o !== exp_cfg) begin n_bad++; $display("FAIL reset_cfg got %h want %h", cfg_o, exp_cfg); end
        n_cmp++; if (miso_oe !== 1'b0) begin n_bad++; $display("FAIL reset_oe got %b want 0", miso_oe); end
        n_cmp++; if (cfg_upd_o !== 1'b0) begin n_bad++; $display("FAIL reset_upd got %b want 0", cfg_upd_o); end
        n_cmp++; if (cfg_addr_o !== 3'd0) begin n_bad++; $display("FAIL reset_addr got %0d want 0", cfg_addr_o); end
        n_cmp++; if (miso_o !== 1'b0) begin n_bad++; $display("FAIL reset_miso got %b want 0", miso_o); end
        u0 = upd_cnt;
        spi_xfer(16'h0000, 16, 1'b1, 1'b0, rd);
        n_cmp++; if (rd !== 8'hEF) begin n_bad++; $display("FAIL reset_read0 got %h want ef", rd); end
        n_cmp++; if (upd_cnt !== u0) begin n_bad++; $display("FAIL reset_read_pulses got %0d want 0", upd_cnt - u0); end
    endtask

    task automatic test_write;
        logic [7:0] rd;
        int         u0;
        u0 = upd_cnt;
        spi_xfer(16'hA05A, 16, 1'b1, 1'b1, rd);
        exp_cfg[23:16] = 8'h5A;
        n_cmp++; if (cfg_o !== exp_cfg) begin n_bad++; $display("FAIL write_cfg got %h want %h", cfg_o, exp_cfg); end
        n_cmp++; if (upd_cnt - u0 !== 1) begin n_bad++; $display("FAIL write_pulses got %0d want 1", upd_cnt - u0); end
        n_cmp++; if (last_addr !== 3'd2) begin n_bad++; $display("FAIL write_addr got %0d want 2", last_addr); end
        n_cmp++; if (lat !== SYNC_STAGES + 2) begin n_bad++; $display("FAIL write_latency got %0d want %0d", lat, SYNC_STAGES + 2); end
        n_cmp++; if (cfg_addr_o !== 3'd2) begin n_bad++; $display("FAIL write_addr_held got %0d want 2", cfg_addr_o); end
    endtask

    task automatic test_readback;
        logic [7:0] rd;
        int         u0;
        u0 = upd_cnt;
        spi_xfer(16'h2000, 16, 1'b1, 1'b0, rd);
        n_cmp++; if (rd !== 8'h5A) begin n_bad++; $display("FAIL readback got %h want 5a", rd); end
        n_cmp++; if (upd_cnt !== u0) begin n_bad++; $display("FAIL readback_pulses got %0d want 0", upd_cnt - u0); end
        n_cmp++; if (cfg_o !== exp_cfg) begin n_bad++; $display("FAIL readback_cfg got %h want %h", cfg_o, exp_cfg); end
    endtask

    task automatic test_abort;
        logic [7:0] rd;
        int         u0;
        u0 = upd_cnt;
        spi_xfer(16'hF0FF, 12, 1'b1, 1'b0, rd);
        n_cmp++; if (upd_cnt !== u0) begin n_bad++; $display("FAIL abort_pulses got %0d want 0", upd_cnt - u0); end
        n_cmp++; if (cfg_o !== exp_cfg) begin n_bad++; $display("FAIL abort_cfg got %h want %h", cfg_o, exp_cfg); end
        spi_xfer(16'hF0C3, 16, 1'b1, 1'b0, rd);
        exp_cfg[63:56] = 8'hC3;
        n_cmp++; if (cfg_o !== exp_cfg) begin n_bad++; $display("FAIL abort_next_cfg got %h want %h", cfg_o, exp_cfg); end
        n_cmp++; if (last_addr !== 3'd7) begin n_bad++; $display("FAIL abort_next_addr got %0d want 7", last_addr); end
    endtask

    task automatic test_overrun;
        logic [7:0] rd;
        int         u0;
        u0 = upd_cnt;
        spi_xfer(16'h9011, 20, 1'b1, 1'b0, rd);
        exp_cfg[15:8] = 8'h11;
        n_cmp++; if (cfg_o !== exp_cfg) begin n_bad++; $display("FAIL overrun_cfg got %h want %h", cfg_o, exp_cfg); end
        n_cmp++; if (upd_cnt - u0 !== 1) begin n_bad++; $display("FAIL overrun_pulses got %0d want 1", upd_cnt - u0); end
        n_cmp++; if (last_addr !== 3'd1) begin n_bad++; $display("FAIL overrun_addr got %0d want 1", last_addr); end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] rd;
        int         u0;
        u0 = upd_cnt;
        spi_xfer(16'hB0AA, 10, 1'b0, 1'b0, rd);
        rst    = 1'b1;
        cs_n_i = 1'b1;
        sclk_i = 1'b0;
        wait_n(2);
        rst = 1'b0;
        wait_n(2 * HALF);
        exp_cfg = RESET_CFG;
        n_cmp++; if (cfg_o !== exp_cfg) begin n_bad++; $display("FAIL midrst_cfg got %h want %h", cfg_o, exp_cfg); end
        n_cmp++; if (miso_oe !== 1'b0) begin n_bad++; $display("FAIL midrst_oe got %b want 0", miso_oe); end
        n_cmp++; if (upd_cnt !== u0) begin n_bad++; $display("FAIL midrst_pulses got %0d want 0", upd_cnt - u0); end
        u0 = upd_cnt;
        spi_xfer(16'hB077, 16, 1'b1, 1'b0, rd);
        exp_cfg[31:24] = 8'h77;
        n_cmp++; if (cfg_o !== exp_cfg) begin n_bad++; $display("FAIL midrst_next_cfg got %h want %h", cfg_o, exp_cfg); end
        n_cmp++; if (upd_cnt - u0 !== 1) begin n_bad++; $display("FAIL midrst_next_pulses got %0d want 1", upd_cnt - u0); end
        n_cmp++; if (last_addr !== 3'd3) begin n_bad++; $display("FAIL midrst_next_addr got %0d want 3", last_addr); end
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        lat     = 0;
        exp_cfg = RESET_CFG;
        rst     = 1'b1;
        cs_n_i  = 1'b1;
        sclk_i  = 1'b0;
        mosi_i  = 1'b0;
        test_reset();
        test_write();
        test_readback();
        test_abort();
        test_overrun();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ucfg_spi_loader.md
Name: ucfg_spi_loader

Overview:
SPI-slave configuration loader that sits directly upstream of the analog IP top level. It converts a 3-wire serial stream from the dedicated input pins into 8 x 8-bit configuration registers. These registers drive the analog macros' static trim, enable and mux bits through a flat bus. The block supports read-back on one output pin so firmware can verify what is programmed.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the synchronizer on each of sclk_i, cs_n_i and mosi_i (minimum 2).
RESET_CFG, 64'h0, reset value of the flat configuration bus; register k takes bits [8k+7:8k].

Ports:
clk  input  1  system clock; must run at least 4x the sclk_i frequency.
rst  input  1  synchronous, active-high reset.
sclk_i  input  1  serial clock, asynchronous to clk.
cs_n_i  input  1  frame select, active low, asynchronous.
mosi_i  input  1  serial data in, MSB first, asynchronous.
miso_o  output  1  serial read-back data.
miso_oe  output  1  output enable for miso_o; high while the synchronized cs_n is low.
cfg_o  output  64  flat configuration bus to the analog IPs.
cfg_upd_o  output  1  one-cycle pulse when a register is written.
cfg_addr_o  output  3  index of the last written register; valid while cfg_upd_o is high, held afterwards.

Behaviour:
- Reset values: cfg_o=RESET_CFG; miso_o=0; miso_oe=0; cfg_upd_o=0; cfg_addr_o=0. Bit counter, shift registers and synchronizers clear; any frame in progress is aborted.
- Synchronizers: each async input passes through a SYNC_STAGES flip-flop chain. Edges are detected on the synchronized sclk by comparing with a one-cycle-delayed copy: a rise samples data, a fall shifts read-back data.
- Frame format, 16 bits MSB first:
  - bit15: W (1=write, 0=read).
  - bits14:12: ADDR.
  - bits11:8: reserved, ignored.
  - bits7:0: DATA.
- Frame FSM states: IDLE, HDR, DATA, DONE.
  - IDLE -> HDR on synchronized cs_n falling; bit counter=0.
  - HDR: each sclk rise shifts mosi into the shift register and increments the counter. After the 8th rise, latch W and ADDR and go to DATA.
  - Read load on HDR->DATA: if W=0, load the read shift register with reg[ADDR]; miso_o shows bit7 from the next clk.
  - DATA, read-back: each sclk fall shifts the read register left once the counter is 9 or more, so bit k is valid before the rise that carries it. miso_o is 0 when W=1.
  - DATA -> DONE on the 16th rise. If W=1, reg[ADDR] <= DATA on the following clk, with cfg_upd_o=1 and cfg_addr_o=ADDR for exactly that cycle.
  - Write latency: cfg_o changes SYNC_STAGES+2 clk cycles after the first clk edge that samples sclk_i high on the 16th bit.
  - DONE: further sclk edges are ignored (counter saturates at 16, no wrap). DONE -> IDLE on synchronized cs_n rising.
- Abort: cs_n rising in HDR or DATA returns to IDLE with no register write and no pulse.
- cs_n falling while not in IDLE restarts the frame at HDR with counter=0. This can only happen after a glitch, since a rise normally intervenes.
- sclk edges while in IDLE are ignored.
- Same-cycle events: a cs_n rise and the 16th sclk rise in the same clk cycle count as abort; no write.
- Read of a register in the same frame sequence as a prior write returns the newly written value, because the write commits before the next frame's header completes.
- rst asserted mid-frame: everything returns to reset values, including cfg_o.

Test Plan:
- Reset: assert rst for 2 cycles -> cfg_o=RESET_CFG, miso_oe=0, cfg_upd_o=0; with RESET_CFG=64'h0123456789ABCDEF, a read of addr 0 returns 8'hEF.
- Write: send 16'hA05A (W=1, ADDR=2, DATA=5A) -> cfg_o[23:16]=8'h5A, exactly one cfg_upd_o pulse with cfg_addr_o=2, other bytes unchanged, latency SYNC_STAGES+2 clk from the 16th rise.
- Read-back: after the write, send 16'h2000 -> miso_o shifts out 0,1,0,1,1,0,1,0 on data bits 7..0; no cfg_upd_o pulse; cfg_o unchanged.
- Abort: send 16'hF0FF but raise cs_n after 12 bits -> no pulse, cfg_o[63:56] unchanged; next full frame 16'hF0C3 -> cfg_o[63:56]=8'hC3.
- Overrun: 20 sclk cycles in one frame with first 16 bits 16'h9011 -> reg1=8'h11, one pulse only; extra bits ignored.
- Reset mid-frame: rst after 10 bits of a write to addr 3 -> addr 3 stays at its reset value; FSM in IDLE; next frame decodes correctly.
